// File: rtl/cmp_relation_tracker.sv
// ============================================================================
// Module   : cmp_relation_tracker
// Brief    : Debounces one-hot comparator flags into a stable relation state,
//            emits change/error events and keeps saturating sample counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cmp_relation_tracker #(
   parameter int DEBOUNCE = 3,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             a_gt_b,
   input  logic             a_eq_b,
   input  logic             a_lt_b,
   input  logic             cnt_clr,
   output logic [1:0]       rel_state,
   output logic             rise_evt,
   output logic             eq_evt,
   output logic             fall_evt,
   output logic             err_evt,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] lt_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [3:0]       C_DEB     = 4'(DEBOUNCE);
   localparam logic [1:0]       C_REL_UNK = 2'd0;
   localparam logic [1:0]       C_REL_LT  = 2'd1;
   localparam logic [1:0]       C_REL_EQ  = 2'd2;
   localparam logic [1:0]       C_REL_GT  = 2'd3;
   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

   logic [1:0] r_cand;
   logic [3:0] r_run;

   logic       w_one_hot;
   logic       w_legal;
   logic       w_illegal;
   logic [1:0] w_code;
   logic [1:0] w_cand_nxt;
   logic [3:0] w_run_nxt;
   logic       w_change;

   // Exactly one flag set; anything else is a malformed comparator output.
   always_comb begin
      w_one_hot = (a_gt_b & ~a_eq_b & ~a_lt_b) |
                  (~a_gt_b & a_eq_b & ~a_lt_b) |
                  (~a_gt_b & ~a_eq_b & a_lt_b);
      w_legal   = in_valid & w_one_hot;
      w_illegal = in_valid & ~w_one_hot;
      if (a_gt_b)
         w_code = C_REL_GT;
      else if (a_eq_b)
         w_code = C_REL_EQ;
      else
         w_code = C_REL_LT;
   end

   always_comb begin
      w_cand_nxt = r_cand;
      w_run_nxt  = r_run;
      if (w_illegal) begin
         w_run_nxt = 4'd0;
      end else if (w_legal) begin
         if ((w_code == r_cand) && (r_run != 4'd0)) begin
            w_run_nxt = (r_run >= C_DEB) ? C_DEB : r_run + 4'd1;
         end else begin
            w_cand_nxt = w_code;
            w_run_nxt  = 4'd1;
         end
      end
      w_change = w_legal && (w_run_nxt == C_DEB) && (w_cand_nxt != rel_state);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cand    <= C_REL_UNK;
         r_run     <= 4'd0;
         rel_state <= C_REL_UNK;
         rise_evt  <= 1'b0;
         eq_evt    <= 1'b0;
         fall_evt  <= 1'b0;
         err_evt   <= 1'b0;
      end else begin
         r_cand    <= w_cand_nxt;
         r_run     <= w_run_nxt;
         rise_evt  <= w_change && (w_cand_nxt == C_REL_GT);
         eq_evt    <= w_change && (w_cand_nxt == C_REL_EQ);
         fall_evt  <= w_change && (w_cand_nxt == C_REL_LT);
         err_evt   <= w_illegal;
         if (w_change)
            rel_state <= w_cand_nxt;
      end
   end

   // Clear beats increment; counters hold at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         gt_cnt  <= '0;
         eq_cnt  <= '0;
         lt_cnt  <= '0;
         err_cnt <= '0;
      end else begin
         if (w_legal && (w_code == C_REL_GT) && (gt_cnt != C_CNT_MAX))
            gt_cnt <= gt_cnt + 1'b1;
         if (w_legal && (w_code == C_REL_EQ) && (eq_cnt != C_CNT_MAX))
            eq_cnt <= eq_cnt + 1'b1;
         if (w_legal && (w_code == C_REL_LT) && (lt_cnt != C_CNT_MAX))
            lt_cnt <= lt_cnt + 1'b1;
         if (w_illegal && (err_cnt != C_CNT_MAX))
            err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cmp_relation_tracker.sv
// ============================================================================
// Module   : tb_cmp_relation_tracker
// Brief    : Table-driven bench for cmp_relation_tracker (DEBOUNCE=3, CNT_W=4)
//            plus a DEBOUNCE=1 instance checked by a short hand sequence.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cmp_relation_tracker;

   localparam logic [2:0] F_GT = 3'b100;
   localparam logic [2:0] F_EQ = 3'b010;
   localparam logic [2:0] F_LT = 3'b001;
   localparam logic [2:0] F_NO = 3'b000;

   typedef struct {
      logic       rst;
      logic       v;
      logic [2:0] f;
      logic       clr;
      logic [1:0] rel;
      logic [3:0] ev;    // {rise, eq, fall, err}
      logic [3:0] gt;
      logic [3:0] eq;
      logic [3:0] lt;
      logic [3:0] er;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst, in_valid, a_gt_b, a_eq_b, a_lt_b, cnt_clr;
   logic [1:0] rel_state, d1_rel;
   logic       rise_evt, eq_evt, fall_evt, err_evt;
   logic       d1_rise, d1_eq, d1_fall, d1_err;
   logic [3:0] gt_cnt, eq_cnt, lt_cnt, err_cnt;
   logic [7:0] d1_gt, d1_eqc, d1_lt, d1_errc;

   int checks = 0;
   int errors = 0;

   vec_t vecs[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   cmp_relation_tracker #(.DEBOUNCE(3), .CNT_W(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .cnt_clr(cnt_clr),
      .rel_state(rel_state), .rise_evt(rise_evt), .eq_evt(eq_evt),
      .fall_evt(fall_evt), .err_evt(err_evt),
      .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .err_cnt(err_cnt)
   );

   cmp_relation_tracker #(.DEBOUNCE(1), .CNT_W(8)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .cnt_clr(cnt_clr),
      .rel_state(d1_rel), .rise_evt(d1_rise), .eq_evt(d1_eq),
      .fall_evt(d1_fall), .err_evt(d1_err),
      .gt_cnt(d1_gt), .eq_cnt(d1_eqc), .lt_cnt(d1_lt), .err_cnt(d1_errc)
   );

   task automatic add(input logic rs, input logic v, input logic [2:0] f,
                      input logic clr, input logic [1:0] rel, input logic [3:0] ev,
                      input int g, input int e, input int l, input int x);
      vec_t t;
      t.rst = rs; t.v = v; t.f = f; t.clr = clr; t.rel = rel; t.ev = ev;
      t.gt = 4'(g); t.eq = 4'(e); t.lt = 4'(l); t.er = 4'(x);
      vecs.push_back(t);
   endtask

   task automatic drive(input logic rs, input logic v, input logic [2:0] f,
                        input logic clr);
      @(negedge clk);
      rst = rs; in_valid = v; cnt_clr = clr;
      {a_gt_b, a_eq_b, a_lt_b} = f;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic apply_vec(input vec_t t, input int idx);
      vec_t e;
      drive(t.rst, t.v, t.f, t.clr);
      sb.push_back(t);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("row%0d rel_state", idx), int'(rel_state), int'(e.rel));
      check($sformatf("row%0d events", idx),
            int'({rise_evt, eq_evt, fall_evt, err_evt}), int'(e.ev));
      check($sformatf("row%0d counters", idx),
            int'({gt_cnt, eq_cnt, lt_cnt, err_cnt}), int'({e.gt, e.eq, e.lt, e.er}));
   endtask

   task automatic step_d1(input logic rs, input logic [2:0] f, input string name,
                          input logic [1:0] rel, input logic [3:0] ev);
      drive(rs, 1'b1, f, 1'b0);
      @(posedge clk);
      #1;
      check({name, " d1 rel_state"}, int'(d1_rel), int'(rel));
      check({name, " d1 events"}, int'({d1_rise, d1_eq, d1_fall, d1_err}), int'(ev));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0;
      {a_gt_b, a_eq_b, a_lt_b} = F_NO;

      // Reset, then clean GT run
      add(1,0,F_NO,0, 0,4'b0000, 0,0,0,0);
      add(0,1,F_GT,0, 0,4'b0000, 1,0,0,0);
      add(0,1,F_GT,0, 0,4'b0000, 2,0,0,0);
      add(0,1,F_GT,0, 3,4'b1000, 3,0,0,0);
      add(0,0,F_NO,0, 3,4'b0000, 3,0,0,0);
      // Bounce rejection
      add(0,1,F_LT,0, 3,4'b0000, 3,0,1,0);
      add(0,1,F_LT,0, 3,4'b0000, 3,0,2,0);
      add(0,1,F_GT,0, 3,4'b0000, 4,0,2,0);
      add(0,1,F_LT,0, 3,4'b0000, 4,0,3,0);
      add(0,1,F_LT,0, 3,4'b0000, 4,0,4,0);
      add(0,1,F_LT,0, 1,4'b0010, 4,0,5,0);
      // Illegal flags restart the run
      add(0,1,F_EQ,0,   1,4'b0000, 4,1,5,0);
      add(0,1,F_EQ,0,   1,4'b0000, 4,2,5,0);
      add(0,1,3'b110,0, 1,4'b0001, 4,2,5,1);
      add(0,1,F_EQ,0,   1,4'b0000, 4,3,5,1);
      add(0,1,F_EQ,0,   1,4'b0000, 4,4,5,1);
      add(0,1,F_EQ,0,   2,4'b0100, 4,5,5,1);
      // Valid gaps do not break the run
      add(0,1,F_GT,0, 2,4'b0000, 5,5,5,1);
      for (int i = 0; i < 5; i++) add(0,0,F_GT,0, 2,4'b0000, 5,5,5,1);
      add(0,1,F_GT,0, 2,4'b0000, 6,5,5,1);
      for (int i = 0; i < 2; i++) add(0,0,F_NO,0, 2,4'b0000, 6,5,5,1);
      add(0,1,F_GT,0, 3,4'b1000, 7,5,5,1);
      add(0,0,F_NO,0, 3,4'b0000, 7,5,5,1);
      // Saturation: run and gt_cnt both hold, no repeat events
      for (int i = 0; i < 20; i++)
         add(0,1,F_GT,0, 3,4'b0000, (8 + i > 15) ? 15 : 8 + i, 5,5,1);
      add(0,1,F_GT,1, 3,4'b0000, 0,0,0,0);
      add(0,1,F_GT,0, 3,4'b0000, 1,0,0,0);
      // Clear still lets the sample debounce
      add(0,1,F_LT,0, 3,4'b0000, 1,0,1,0);
      add(0,1,F_LT,0, 3,4'b0000, 1,0,2,0);
      add(0,1,F_LT,1, 1,4'b0010, 0,0,0,0);
      add(0,0,F_NO,0, 1,4'b0000, 0,0,0,0);
      // Reset mid-debounce, with valid and clear also asserted
      add(1,1,F_LT,1, 0,4'b0000, 0,0,0,0);
      add(0,1,F_LT,0, 0,4'b0000, 0,0,1,0);
      add(0,1,F_LT,0, 0,4'b0000, 0,0,2,0);
      add(1,0,F_NO,0, 0,4'b0000, 0,0,0,0);
      add(0,1,F_LT,0, 0,4'b0000, 0,0,1,0);
      add(0,1,F_LT,0, 0,4'b0000, 0,0,2,0);
      add(0,1,F_LT,0, 1,4'b0010, 0,0,3,0);
      // Illegal sample with no flags set
      add(0,1,F_NO,0, 1,4'b0001, 0,0,3,1);
      add(0,0,F_NO,0, 1,4'b0000, 0,0,3,1);

      for (int i = 0; i < vecs.size(); i++)
         apply_vec(vecs[i], i);

      // DEBOUNCE=1: every differing legal sample switches immediately
      step_d1(1'b1, F_NO, "d1 reset", 2'd0, 4'b0000);
      step_d1(1'b0, F_LT, "d1 LT",    2'd1, 4'b0010);
      step_d1(1'b0, F_EQ, "d1 EQ",    2'd2, 4'b0100);
      step_d1(1'b0, 3'b111, "d1 ill", 2'd2, 4'b0001);
      step_d1(1'b0, F_EQ, "d1 EQ2",   2'd2, 4'b0000);
      step_d1(1'b0, F_GT, "d1 GT",    2'd3, 4'b1000);
      check("d1 gt_cnt", int'(d1_gt), 1);
      check("d1 err_cnt", int'(d1_errc), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
